// File: rtl/sprite_pkg.sv
// Shared types and default geometry for the sprite pipeline (sprite_movement / sprite_render).
package sprite_pkg;

  typedef logic [7:0] coord_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } load_state_t;

  localparam int SPRITE_WIDTH  = 8;
  localparam int SPRITE_HEIGHT = 12;
  localparam int SCALE_SHIFT   = 3;
  localparam int BEAM_W        = 10;

endpackage

// File: rtl/sprite_render_if.sv
// Serial bitmap load channel: the master streams bits in, the renderer reports busy/done.
interface sprite_render_if;

  logic load_start;
  logic load_valid;
  logic load_bit;
  logic load_busy;
  logic load_done;

  modport master (
    output load_start,
    output load_valid,
    output load_bit,
    input  load_busy,
    input  load_done
  );

  modport slave (
    input  load_start,
    input  load_valid,
    input  load_bit,
    output load_busy,
    output load_done
  );

endinterface

// File: rtl/sprite_bitmap.sv
// 1bpp sprite bitmap storage: a W*H shift register filled serially by a small load FSM.
// The first bit loaded ends up at index 0 (top-left), so bits shift in at the MSB.
module sprite_bitmap
  import sprite_pkg::*;
#(
  parameter int WIDTH  = sprite_pkg::SPRITE_WIDTH,
  parameter int HEIGHT = sprite_pkg::SPRITE_HEIGHT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_start,
  input  logic                      load_valid,
  input  logic                      load_bit,
  output logic [WIDTH*HEIGHT-1:0]   bitmap,
  output logic                      busy,
  output logic                      done
);

  localparam int NBITS = WIDTH * HEIGHT;
  localparam int CNT_W = $clog2(NBITS);

  load_state_t        state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NBITS-1:0]   shift_q, shift_d;
  logic               done_q,  done_d;

  // Next-state logic: a start (even mid-load) always restarts the count and drops any bit that cycle
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    if (load_start) begin
      state_d = LOAD;
      count_d = '0;
    end else if (state_q == LOAD && load_valid) begin
      shift_d = {load_bit, shift_q[NBITS-1:1]};
      if (count_q == CNT_W'(NBITS - 1)) begin
        state_d = IDLE;
        count_d = '0;
        done_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // State, counter and bitmap registers; reset clears the bitmap and aborts any load
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  assign bitmap = shift_q;
  assign busy   = (state_q == LOAD);
  assign done   = done_q;

endmodule

// File: rtl/sprite_render.sv
// Per-pixel sprite overlay: maps the VGA beam onto the coarse grid, tests it against the
// sprite bounding box and looks up the bitmap bit. Two register stages, beam-to-output N+2.
module sprite_render
  import sprite_pkg::*;
#(
  parameter int SPRITE_WIDTH  = sprite_pkg::SPRITE_WIDTH,
  parameter int SPRITE_HEIGHT = sprite_pkg::SPRITE_HEIGHT,
  parameter int SCALE_SHIFT   = sprite_pkg::SCALE_SHIFT,
  parameter int BEAM_W        = sprite_pkg::BEAM_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BEAM_W-1:0]  counter_h,
  input  logic [BEAM_W-1:0]  counter_v,
  input  logic               display_on,
  input  coord_t             sprite_x,
  input  coord_t             sprite_y,
  sprite_render_if.slave     load_if,
  output logic               in_box,
  output logic               pixel_on
);

  localparam int NBITS = SPRITE_WIDTH * SPRITE_HEIGHT;
  localparam int IDX_W = $clog2(NBITS);

  logic [NBITS-1:0] bitmap;
  logic             busy_w;
  logic             done_w;

  sprite_bitmap #(
    .WIDTH  (SPRITE_WIDTH),
    .HEIGHT (SPRITE_HEIGHT)
  ) u_bitmap (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_if.load_start),
    .load_valid (load_if.load_valid),
    .load_bit   (load_if.load_bit),
    .bitmap     (bitmap),
    .busy       (busy_w),
    .done       (done_w)
  );

  assign load_if.load_busy = busy_w;
  assign load_if.load_done = done_w;

  coord_t       xs, ys;
  logic         hit_x, hit_y;
  logic [15:0]  pix_idx;
  logic         pix_bit;

  logic         box_q,      box_d;
  coord_t       dx_q,       dx_d;
  coord_t       dy_q,       dy_d;
  logic         in_box_q,   in_box_d;
  logic         pixel_on_q, pixel_on_d;

  // Box test uses 9-bit sums so a sprite near coarse 255 clips instead of wrapping to 0
  always_comb begin
    xs      = coord_t'(counter_h >> SCALE_SHIFT);
    ys      = coord_t'(counter_v >> SCALE_SHIFT);
    hit_x   = (xs >= sprite_x) && ({1'b0, xs} < ({1'b0, sprite_x} + 9'(SPRITE_WIDTH)));
    hit_y   = (ys >= sprite_y) && ({1'b0, ys} < ({1'b0, sprite_y} + 9'(SPRITE_HEIGHT)));
    box_d   = hit_x & hit_y & display_on;
    dx_d    = xs - sprite_x;
    dy_d    = ys - sprite_y;
    pix_idx = 16'(dy_q) * 16'(SPRITE_WIDTH) + 16'(dx_q);
    pix_bit = (pix_idx < 16'(NBITS)) ? bitmap[pix_idx[IDX_W-1:0]] : 1'b0;
    in_box_d   = box_q;
    pixel_on_d = box_q & pix_bit & ~busy_w;
  end

  // Beam pipeline registers; the half-loaded bitmap is hidden while a load is running
  always_ff @(posedge clk) begin
    if (reset) begin
      box_q      <= 1'b0;
      dx_q       <= '0;
      dy_q       <= '0;
      in_box_q   <= 1'b0;
      pixel_on_q <= 1'b0;
    end else begin
      box_q      <= box_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      in_box_q   <= in_box_d;
      pixel_on_q <= pixel_on_d;
    end
  end

  assign in_box   = in_box_q;
  assign pixel_on = pixel_on_q;

endmodule
